global_mem_arbiter: RTL and testbench

- Shares the single core-side port of global_mem_controller among NUM_CORES cores.
- Each core sees an individual memory port with the same protocol as the controller's core port: rd_req/wr_req, addr, wr_data, rd_data, busy, ack.
- Requests are latched per core, granted round-robin, and issued to memory one at a time.
- Used by the multi-core GPU top in place of the direct core-to-memory hookup.

---
 rtl/global_mem_arbiter_pkg.sv | 21 ++
 rtl/global_mem_arbiter_rr_arbiter.sv | 32 +++
 rtl/global_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_global_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/global_mem_arbiter_pkg.sv
// Shared types and widths for the global memory arbiter.
package global_mem_arbiter_pkg;

    localparam int unsigned addr_width = 32;
    localparam int unsigned data_width = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_e;

    // One latched request per core; valid doubles as the core's busy flag.
    typedef struct packed {
        logic                  valid;
        logic                  is_wr;
        logic [addr_width-1:0] addr;
        logic [data_width-1:0] wr_data;
    } mem_req_slot_t;

endpackage

// File: rtl/global_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first pending index after last_grant, wrapping.
module global_mem_arbiter_rr_arbiter
    import global_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IdxW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0] pending_i,
    input  logic [IdxW-1:0]      last_grant_i,
    output logic [IdxW-1:0]      grant_o,
    output logic                 any_valid_o
);

    // Lowest pending index is the wrap-around fallback; the lowest pending index
    // above last_grant overrides it when one exists.
    always_comb begin
        grant_o     = '0;
        any_valid_o = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                grant_o     = IdxW'(i);
                any_valid_o = 1'b1;
            end
        end
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (pending_i[i] && (i > int'(last_grant_i))) begin
                grant_o = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/global_mem_arbiter.sv
// Shares one global_mem_controller core port among NUM_CORES cores, one request at a time.
module global_mem_arbiter
    import global_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned addr_width = global_mem_arbiter_pkg::addr_width,
    parameter int unsigned data_width = global_mem_arbiter_pkg::data_width
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            core_rd_req,
    input  logic [NUM_CORES-1:0]            core_wr_req,
    input  logic [NUM_CORES*addr_width-1:0] core_addr,
    input  logic [NUM_CORES*data_width-1:0] core_wr_data,
    output logic [data_width-1:0]           core_rd_data,
    output logic [NUM_CORES-1:0]            core_busy,
    output logic [NUM_CORES-1:0]            core_ack,
    output logic [addr_width-1:0]           mem_addr,
    output logic                            mem_rd_req,
    output logic                            mem_wr_req,
    output logic [data_width-1:0]           mem_wr_data,
    input  logic [data_width-1:0]           mem_rd_data,
    input  logic                            mem_busy,
    input  logic                            mem_ack
);

    localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    arb_state_e            state_q, state_d;
    mem_req_slot_t         slots_q [NUM_CORES];
    mem_req_slot_t         slots_d [NUM_CORES];
    logic [IdxW-1:0]       grant_q, grant_d;
    logic [IdxW-1:0]       last_grant_q, last_grant_d;
    logic [NUM_CORES-1:0]  core_ack_q, core_ack_d;
    logic [data_width-1:0] rd_data_q, rd_data_d;
    logic [addr_width-1:0] mem_addr_q, mem_addr_d;
    logic [data_width-1:0] mem_wr_data_q, mem_wr_data_d;
    logic                  mem_rd_req_q, mem_rd_req_d;
    logic                  mem_wr_req_q, mem_wr_req_d;
    logic [NUM_CORES-1:0]  pending;
    logic [IdxW-1:0]       arb_grant;
    logic                  arb_valid;

    // Pending vector seen by the arbiter is simply the slot valid bits.
    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            pending[i] = slots_q[i].valid;
        end
    end

    global_mem_arbiter_rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IdxW      (IdxW)
    ) u_rr_arbiter (
        .pending_i    (pending),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .any_valid_o  (arb_valid)
    );

    // Slot capture plus the IDLE/ISSUE/WAIT sequencer. The mem req is decided one
    // cycle ahead so the registered pulse lands in the first ISSUE cycle.
    always_comb begin
        state_d       = state_q;
        slots_d       = slots_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        core_ack_d    = '0;
        rd_data_d     = rd_data_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_rd_req_d  = 1'b0;
        mem_wr_req_d  = 1'b0;

        // Capture never collides with the slot being retired: that one is still valid.
        for (int i = 0; i < NUM_CORES; i++) begin
            if ((core_rd_req[i] || core_wr_req[i]) && !slots_q[i].valid) begin
                slots_d[i].valid   = 1'b1;
                slots_d[i].is_wr   = core_wr_req[i];  // rd+wr together resolves to write
                slots_d[i].addr    = core_addr[i*addr_width +: addr_width];
                slots_d[i].wr_data = core_wr_data[i*data_width +: data_width];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d       = arb_grant;
                    mem_addr_d    = slots_q[arb_grant].addr;
                    mem_wr_data_d = slots_q[arb_grant].wr_data;
                    mem_rd_req_d  = !mem_busy && !slots_q[arb_grant].is_wr;
                    mem_wr_req_d  = !mem_busy && slots_q[arb_grant].is_wr;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_rd_req_q || mem_wr_req_q) begin
                    state_d = WAIT;
                end else if (!mem_busy) begin
                    mem_rd_req_d = !slots_q[grant_q].is_wr;
                    mem_wr_req_d = slots_q[grant_q].is_wr;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    core_ack_d[grant_q]    = 1'b1;
                    slots_d[grant_q].valid = 1'b0;
                    if (!slots_q[grant_q].is_wr) begin
                        rd_data_d = mem_rd_data;
                    end
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; last_grant resets to the top index so core 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= IdxW'(NUM_CORES - 1);
            core_ack_q    <= '0;
            rd_data_q     <= '0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_rd_req_q  <= 1'b0;
            mem_wr_req_q  <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            core_ack_q    <= core_ack_d;
            rd_data_q     <= rd_data_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_wr_req_q  <= mem_wr_req_d;
            slots_q       <= slots_d;
        end
    end

    assign core_rd_data = rd_data_q;
    assign core_busy    = pending;
    assign core_ack     = core_ack_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wr_data  = mem_wr_data_q;
    assign mem_rd_req   = mem_rd_req_q;
    assign mem_wr_req   = mem_wr_req_q;

    // Protocol misuse is tolerated by the datapath but reported in simulation.
    a_req_while_busy: assert property (@(posedge clk) disable iff (!rst)
        ((core_rd_req | core_wr_req) & pending) == '0)
        else $warning("request on busy core ignored");
    a_rd_and_wr: assert property (@(posedge clk) disable iff (!rst)
        (core_rd_req & core_wr_req) == '0)
        else $warning("simultaneous rd and wr request treated as write");
    a_stray_ack: assert property (@(posedge clk) disable iff (!rst)
        mem_ack |-> (state_q == WAIT))
        else $warning("mem_ack outside WAIT ignored");

endmodule

// File: tb/tb_global_mem_arbiter.sv
// Scoreboard bench for global_mem_arbiter with a small memory responder model.
module tb_global_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    core_rd_req, core_wr_req;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wr_data;
    logic [DW-1:0]   core_rd_data;
    logic [N-1:0]    core_busy, core_ack;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd_req, mem_wr_req;
    logic [DW-1:0]   mem_wr_data, mem_rd_data;
    logic            mem_busy, mem_ack;

    global_mem_arbiter #(
        .NUM_CORES  (N),
        .addr_width (AW),
        .data_width (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_rd_req  (core_rd_req),
        .core_wr_req  (core_wr_req),
        .core_addr    (core_addr),
        .core_wr_data (core_wr_data),
        .core_rd_data (core_rd_data),
        .core_busy    (core_busy),
        .core_ack     (core_ack),
        .mem_addr     (mem_addr),
        .mem_rd_req   (mem_rd_req),
        .mem_wr_req   (mem_wr_req),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data),
        .mem_busy     (mem_busy),
        .mem_ack      (mem_ack)
    );

    typedef struct {
        int          core;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] mem_store[logic [31:0]];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_mem_req = 0;
    int          rst_epoch = 0;
    int          mem_lat = 1;
    int          ack_per_core[N];
    logic [31:0] last_rd = '0;
    txn_t        mon_e;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_reqs();
        core_rd_req = '0;
        core_wr_req = '0;
    endtask

    // Drive a one-cycle request and push its expected completion.
    task automatic issue(input int c, input bit wr, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        if (wr) core_wr_req[c] = 1'b1;
        else    core_rd_req[c] = 1'b1;
        core_addr[c*AW +: AW]    = a;
        core_wr_data[c*DW +: DW] = d;
        t.core  = c;
        t.is_wr = wr;
        t.addr  = a;
        if (wr) begin
            t.data    = d;
            ref_mem[a] = d;
        end else begin
            t.data = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        end
        exp_q.push_back(t);
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || core_busy != '0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < max_cyc, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        last_rd = '0;
        rst_epoch++;
        clear_reqs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Memory responder: checks each issued request against the scoreboard head.
    initial begin
        logic [31:0] a, d;
        bit          wr;
        int          ep;
        mem_ack     = 1'b0;
        mem_rd_data = 32'hFFFF_FFFF;
        forever begin
            @(negedge clk);
            if (rst && (mem_rd_req || mem_wr_req)) begin
                ep = rst_epoch;
                a  = mem_addr;
                d  = mem_wr_data;
                wr = mem_wr_req;
                n_mem_req++;
                if (exp_q.size() == 0) begin
                    chk("mem_req_unexpected", exp_q.size(), 1);
                end else begin
                    chk("mem_addr", a, exp_q[0].addr);
                    chk("mem_op", wr, exp_q[0].is_wr);
                    if (wr) chk("mem_wr_data", d, exp_q[0].data);
                end
                if (wr) mem_store[a] = d;
                @(negedge clk);
                chk("mem_req_pulse", mem_rd_req | mem_wr_req, 0);
                repeat (mem_lat - 1) @(negedge clk);
                mem_ack     = 1'b1;
                mem_rd_data = wr ? 32'hBAD0_BAD0 : (mem_store.exists(a) ? mem_store[a] : dflt(a));
                if (ep == rst_epoch) chk("mem_addr_stable", mem_addr, a);
                @(negedge clk);
                mem_ack     = 1'b0;
                mem_rd_data = 32'hFFFF_FFFF;
            end
        end
    end

    // Completion monitor: pops the scoreboard on every core_ack.
    always @(negedge clk) begin
        if (rst && core_ack != '0) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", core_ack, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_core", core_ack, 1 << mon_e.core);
                chk("ack_rd_data", core_rd_data, mon_e.is_wr ? last_rd : mon_e.data);
                if (!mon_e.is_wr) last_rd = mon_e.data;
                ack_per_core[mon_e.core]++;
            end
        end else if (rst) begin
            chk("rd_data_hold", core_rd_data, last_rd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int base[N];
        int remaining;
        int n;
        int p0;
        clear_reqs();
        core_addr    = '0;
        core_wr_data = '0;
        mem_busy     = 1'b0;
        for (int c = 0; c < N; c++) ack_per_core[c] = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", core_busy, 0);
        chk("rst_ack", core_ack, 0);
        chk("rst_mem_rd", mem_rd_req, 0);
        chk("rst_mem_wr", mem_wr_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rd_data", core_rd_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single read: req cycle 0, mem req 2, ack 3, core_ack 4
        mem_store[32'h40] = 32'h1234;
        ref_mem[32'h40]   = 32'h1234;
        issue(0, 1'b0, 32'h40, 32'h0);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j == 1) clear_reqs();
            chk("rd1_busy", core_busy[0], j <= 3);
            chk("rd1_ack", core_ack[0], j == 4);
        end
        chk("rd1_data", core_rd_data, 32'h1234);
        wait_done(50, "rd1_done");

        // Simultaneous requests on cores 1 and 3
        issue(1, 1'b0, 32'h200, 32'h0);
        issue(3, 1'b0, 32'h300, 32'h0);
        @(negedge clk);
        clear_reqs();
        wait_done(100, "sim_done");

        // Round-robin: every core re-requests in its ack cycle, 12 transactions
        for (int c = 0; c < N; c++) base[c] = ack_per_core[c];
        for (int c = 0; c < N; c++) issue(c, 1'b0, 32'h1000 + c * 16, 32'h0);
        remaining = 8;
        n = 0;
        while ((remaining > 0 || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
            clear_reqs();
            for (int c = 0; c < N; c++) begin
                if (core_ack[c] && remaining > 0) begin
                    issue(c, 1'b0, 32'h1000 + c * 16 + remaining * 256, 32'h0);
                    remaining--;
                end
            end
        end
        clear_reqs();
        chk("rr_done", n < 400, 1);
        for (int c = 0; c < N; c++) chk("rr_acks_per_core", ack_per_core[c] - base[c], 3);

        // mem_busy stall while in ISSUE
        mem_busy = 1'b1;
        p0 = n_mem_req;
        issue(0, 1'b0, 32'h440, 32'h0);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 1) clear_reqs();
            chk("stall_no_req", mem_rd_req, 0);
            chk("stall_busy", core_busy[0], 1);
            if (j >= 2) chk("stall_addr", mem_addr, 32'h440);
        end
        mem_busy = 1'b0;
        wait_done(50, "stall_done");
        chk("stall_one_req", n_mem_req - p0, 1);

        // Write then read back on core 2
        issue(2, 1'b1, 32'h80, 32'hDEAD_BEEF);
        @(negedge clk);
        clear_reqs();
        wait_done(50, "wr_done");
        issue(2, 1'b0, 32'h80, 32'h0);
        @(negedge clk);
        clear_reqs();
        wait_done(50, "rd_back_done");
        chk("wr_rd_data", core_rd_data, 32'hDEAD_BEEF);

        // Reset while WAITing, then a stray late mem_ack
        mem_lat = 8;
        p0 = n_mem_req;
        issue(0, 1'b0, 32'h500, 32'h0);
        @(negedge clk);
        clear_reqs();
        n = 0;
        while (n_mem_req == p0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rw_issued", n_mem_req - p0, 1);
        repeat (2) @(negedge clk);
        do_reset();
        chk("rw_busy", core_busy, 0);
        chk("rw_ack", core_ack, 0);
        chk("rw_mem_rd", mem_rd_req, 0);
        chk("rw_mem_addr", mem_addr, 0);
        chk("rw_rd_data", core_rd_data, 0);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("rw_no_ack", core_ack, 0);
            chk("rw_no_busy", core_busy, 0);
        end
        mem_lat = 1;

        // After reset core 0 wins over core 3
        issue(0, 1'b0, 32'h700, 32'h0);
        issue(3, 1'b0, 32'h600, 32'h0);
        @(negedge clk);
        clear_reqs();
        wait_done(100, "post_rst_done");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
